// File: rtl/timer_pkg.sv
// Register map, field positions and byte-lane merge helper for the wb_timer block.
package timer_pkg;

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_COUNT   = 2'd1;
   localparam logic [1:0] REG_COMPARE = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_RELOAD   = 2;
   localparam int PRESCALE_LSB  = 8;
   localparam int PRESCALE_MSB  = 15;
   localparam int STATUS_MATCH  = 0;

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
      return r;
   endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone slave bus bundle (classic single-transfer subset, tags omitted).
interface wishboneSlave;
   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [3:0]  sel_i;
   logic [31:0] adr_i;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack_o;

   modport slave  (input cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, output dat_o, ack_o);
   modport master (output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, input dat_o, ack_o);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for wb_timer: one tick every limit+1 enabled cycles.
// Only built when TIMER_PRESCALER_EN is defined.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] limit,
   output logic       tick
);
   logic [7:0] cnt;

   assign tick = enable && (cnt == limit);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                cnt <= '0;
      else if (!enable || tick)  cnt <= '0;
      else                       cnt <= cnt + 8'd1;
   end
endmodule
`endif

// File: rtl/wb_timer.sv
// Wishbone interval timer: 32-bit counter with compare match and level irq.
// Define TIMER_PRESCALER_EN to build the 8-bit prescaler and CTRL.PRESCALE.
module wb_timer
   import timer_pkg::*;
#(
   parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF,
   parameter logic [7:0]  RESET_PRESCALE = 8'd0
) (
   input  logic         clock,
   input  logic         reset,
   wishboneSlave.slave  bus,
   output logic         irq
);
   logic        en, irq_en, reload, match;
   logic [7:0]  prescale;
   logic [31:0] count, compare;
   logic [31:0] ctrl_rd, rd_data;
   logic        req, tick, hit;
   logic        wr_ctrl, wr_count, wr_compare, wr_status;
   logic        unused_adr;

   assign unused_adr = ^{bus.adr_i[31:4], bus.adr_i[1:0]};

   // A new transfer is accepted only while ack is low, giving one transfer per two clocks.
   assign req        = bus.cyc_i & bus.stb_i & ~bus.ack_o;
   assign wr_ctrl    = req & bus.we_i & (bus.adr_i[3:2] == REG_CTRL);
   assign wr_count   = req & bus.we_i & (bus.adr_i[3:2] == REG_COUNT);
   assign wr_compare = req & bus.we_i & (bus.adr_i[3:2] == REG_COMPARE);
   assign wr_status  = req & bus.we_i & (bus.adr_i[3:2] == REG_STATUS);

`ifdef TIMER_PRESCALER_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                       prescale <= RESET_PRESCALE;
      else if (wr_ctrl && bus.sel_i[1]) prescale <= bus.dat_i[PRESCALE_MSB:PRESCALE_LSB];
   end

   timer_prescaler u_prescaler (
      .clock  (clock),
      .reset  (reset),
      .enable (en),
      .limit  (prescale),
      .tick   (tick)
   );
`else
   localparam logic [7:0] UNUSED_RESET_PRESCALE = RESET_PRESCALE;
   assign prescale = '0;
   assign tick     = en;
`endif

   assign hit = tick && (count == compare);
   assign irq = match & irq_en;

   // Bus writes are ordered last so they override the tick update of the same register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         en      <= 1'b0;
         irq_en  <= 1'b0;
         reload  <= 1'b0;
         count   <= '0;
         compare <= RESET_COMPARE;
         match   <= 1'b0;
      end else begin
         if (tick) begin
            if (hit) begin
               count <= '0;
               if (!reload) en <= 1'b0;
            end else begin
               count <= count + 32'd1;
            end
         end
         if (hit)
            match <= 1'b1;
         else if (wr_status && bus.sel_i[0] && bus.dat_i[STATUS_MATCH])
            match <= 1'b0;
         if (wr_ctrl) begin
            en     <= bus.sel_i[0] ? bus.dat_i[CTRL_EN]     : en;
            irq_en <= bus.sel_i[0] ? bus.dat_i[CTRL_IRQ_EN] : irq_en;
            reload <= bus.sel_i[0] ? bus.dat_i[CTRL_RELOAD] : reload;
         end
         if (wr_count)   count   <= byte_merge(count, bus.dat_i, bus.sel_i);
         if (wr_compare) compare <= byte_merge(compare, bus.dat_i, bus.sel_i);
      end
   end

   always_comb begin
      ctrl_rd                             = '0;
      ctrl_rd[CTRL_EN]                    = en;
      ctrl_rd[CTRL_IRQ_EN]                = irq_en;
      ctrl_rd[CTRL_RELOAD]                = reload;
      ctrl_rd[PRESCALE_MSB:PRESCALE_LSB]  = prescale;
      rd_data                             = '0;
      case (bus.adr_i[3:2])
         REG_CTRL:    rd_data = ctrl_rd;
         REG_COUNT:   rd_data = count;
         REG_COMPARE: rd_data = compare;
         default:     rd_data[STATUS_MATCH] = match;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.ack_o <= 1'b0;
         bus.dat_o <= '0;
      end else begin
         bus.ack_o <= req;
         bus.dat_o <= (req && !bus.we_i) ? rd_data : '0;
      end
   end

endmodule

// File: tb/tb_wb_timer.sv
// Directed self-checking bench for wb_timer; expectations are hand-derived cycle counts.
module tb_wb_timer;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic irq;
   int   n_vec = 0;
   int   n_err = 0;

   localparam logic [31:0] A_CTRL = 32'hF000_0000;
   localparam logic [31:0] A_CNT  = 32'hF000_0004;
   localparam logic [31:0] A_CMP  = 32'hF000_0008;
   localparam logic [31:0] A_STAT = 32'hF000_000C;
`ifdef TIMER_PRESCALER_EN
   localparam int          PS_HIT   = 8;
   localparam logic [31:0] CTRL_B1  = 32'h0000_0502;
`else
   localparam int          PS_HIT   = 2;
   localparam logic [31:0] CTRL_B1  = 32'h0000_0002;
`endif

   wishboneSlave bus();

   wb_timer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .irq   (irq)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
      bus.sel_i = 4'h0; bus.adr_i = '0;   bus.dat_i = '0;
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      @(posedge clock); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
      bus.adr_i = a;    bus.dat_i = d;    bus.sel_i = s;
      @(posedge clock); #1;
      bus_idle();
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
      @(posedge clock); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
      bus.adr_i = a;    bus.sel_i = 4'hF;
      @(posedge clock); #1;
      d   = bus.dat_o;
      ack = bus.ack_o;
      bus_idle();
   endtask

   task automatic quiesce();
      wb_write(A_CTRL, 32'h0, 4'hF);
      wb_write(A_STAT, 32'h1, 4'hF);
      wb_write(A_CNT,  32'h0, 4'hF);
   endtask

   logic [31:0] rd;
   logic        ak;

   initial begin
      bus_idle();
      #2;
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_ack", {31'd0, bus.ack_o}, 32'd0);
      #21 reset = 1'b1;

      // reset values, each ack one cycle after stb
      wb_read(A_CTRL, rd, ak); check("r_ctrl", rd, 32'h0);         check("r_ctrl_ack", {31'd0, ak}, 32'd1);
      wb_read(A_CNT,  rd, ak); check("r_cnt",  rd, 32'h0);         check("r_cnt_ack",  {31'd0, ak}, 32'd1);
      wb_read(A_CMP,  rd, ak); check("r_cmp",  rd, 32'hFFFF_FFFF); check("r_cmp_ack",  {31'd0, ak}, 32'd1);
      wb_read(A_STAT, rd, ak); check("r_stat", rd, 32'h0);         check("r_stat_ack", {31'd0, ak}, 32'd1);

      // free-running reload, compare 5: match one cycle after the 6th tick
      wb_write(A_CMP, 32'd5, 4'hF);
      wb_write(A_CTRL, 32'h7, 4'hF);
      repeat (5) @(posedge clock); #1;
      check("fr_irq_pre", {31'd0, irq}, 32'd0);
      @(posedge clock); #1;
      check("fr_irq_hit", {31'd0, irq}, 32'd1);
      wb_read(A_CNT, rd, ak);
      check("fr_cnt_wrap", rd, 32'd1);
      wb_write(A_STAT, 32'h1, 4'hF);
      check("fr_w1c_irq", {31'd0, irq}, 32'd0);

      // one-shot
      quiesce();
      wb_write(A_CMP, 32'd3, 4'hF);
      wb_write(A_CTRL, 32'h1, 4'hF);
      repeat (8) @(posedge clock);
      wb_read(A_CTRL, rd, ak); check("os_ctrl", rd, 32'h0);
      wb_read(A_CNT,  rd, ak); check("os_cnt",  rd, 32'h0);
      wb_read(A_STAT, rd, ak); check("os_stat", rd, 32'h1);
      check("os_irq_masked", {31'd0, irq}, 32'd0);
      wb_write(A_STAT, 32'h1, 4'b1110);
      wb_read(A_STAT, rd, ak); check("w1c_nosel", rd, 32'h1);
      wb_write(A_STAT, 32'h1, 4'hF);
      wb_read(A_STAT, rd, ak); check("w1c_sel", rd, 32'h0);

      // match every tick: set wins over simultaneous W1C
      quiesce();
      wb_write(A_CMP, 32'd0, 4'hF);
      wb_write(A_CTRL, 32'h5, 4'hF);
      wb_write(A_STAT, 32'h1, 4'hF);
      wb_read(A_STAT, rd, ak); check("set_beats_clr", rd, 32'h1);

      // 32-bit wrap without match
      quiesce();
      wb_write(A_CMP, 32'd2, 4'hF);
      wb_write(A_CNT, 32'hFFFF_FFFE, 4'hF);
      wb_write(A_CTRL, 32'h7, 4'hF);
      @(posedge clock);
      wb_read(A_CNT, rd, ak); check("wrap_cnt", rd, 32'h0);
      @(posedge clock); #1;
      check("wrap_irq_pre", {31'd0, irq}, 32'd0);
      @(posedge clock); #1;
      check("wrap_irq_hit", {31'd0, irq}, 32'd1);

      // prescale 3, compare 1
      quiesce();
      wb_write(A_CMP, 32'd1, 4'hF);
      wb_write(A_CTRL, 32'h0307, 4'hF);
      repeat (PS_HIT - 1) @(posedge clock); #1;
      check("ps_irq_pre", {31'd0, irq}, 32'd0);
      @(posedge clock); #1;
      check("ps_irq_hit", {31'd0, irq}, 32'd1);

      // byte-lane CTRL write, then reset mid-transfer
      wb_write(A_CTRL, 32'h2, 4'hF);
      check("b_irq_hold", {31'd0, irq}, 32'd1);
      wb_write(A_CTRL, 32'h0000_0500, 4'b0010);
      wb_read(A_CTRL, rd, ak); check("b_ctrl", rd, CTRL_B1);
      wb_write(A_CMP, 32'h1234, 4'hF);
      wb_write(A_CNT, 32'h55, 4'hF);
      @(posedge clock); #1;
      bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
      bus.adr_i = A_CMP; bus.dat_i = 32'hAAAA_AAAA; bus.sel_i = 4'hF;
      #2 reset = 1'b0;
      #1;
      check("mr_ack", {31'd0, bus.ack_o}, 32'd0);
      check("mr_irq", {31'd0, irq}, 32'd0);
      check("mr_dat", bus.dat_o, 32'h0);
      @(negedge clock);
      check("mr_ack_n1", {31'd0, bus.ack_o}, 32'd0);
      bus_idle();
      @(negedge clock);
      check("mr_ack_n2", {31'd0, bus.ack_o}, 32'd0);
      #2 reset = 1'b1;
      wb_read(A_CTRL, rd, ak); check("mr_ctrl", rd, 32'h0);
      wb_read(A_CNT,  rd, ak); check("mr_cnt",  rd, 32'h0);
      wb_read(A_CMP,  rd, ak); check("mr_cmp",  rd, 32'hFFFF_FFFF);
      wb_read(A_STAT, rd, ak); check("mr_stat", rd, 32'h0);
      check("mr_irq_end", {31'd0, irq}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
